// File: rtl/data_mem_arb_pkg.sv
// Shared types for the two-requester data memory arbiter.
// Request bundle layout, ownership states and requester index type.
package data_mem_arb_pkg;

   localparam int unsigned DW = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   typedef logic req_idx_t;

   typedef struct packed {
      logic          we;
      logic          byte_op;
      logic [DW-1:0] addr;
      logic [DW-1:0] wd;
   } mem_req_t;

   function automatic req_idx_t other(input req_idx_t idx);
      return ~idx;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester, response and memory-side signals of the data memory arbiter.
// master = requesters plus memory model, slave = arbiter.
interface data_mem_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  r0_req;
   logic                  r0_we;
   logic                  r0_byte_op;
   logic                  r0_lock;
   logic [DATA_WIDTH-1:0] r0_addr;
   logic [DATA_WIDTH-1:0] r0_wd;
   logic                  r0_gnt;
   logic                  r0_rvalid;
   logic [DATA_WIDTH-1:0] r0_rdata;

   logic                  r1_req;
   logic                  r1_we;
   logic                  r1_byte_op;
   logic                  r1_lock;
   logic [DATA_WIDTH-1:0] r1_addr;
   logic [DATA_WIDTH-1:0] r1_wd;
   logic                  r1_gnt;
   logic                  r1_rvalid;
   logic [DATA_WIDTH-1:0] r1_rdata;

   logic                  mem_we;
   logic                  mem_byte_op;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wd;
   logic [DATA_WIDTH-1:0] mem_rd;

   modport master (
      output r0_req, r0_we, r0_byte_op, r0_lock, r0_addr, r0_wd,
      input  r0_gnt, r0_rvalid, r0_rdata,
      output r1_req, r1_we, r1_byte_op, r1_lock, r1_addr, r1_wd,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  mem_we, mem_byte_op, mem_addr, mem_wd,
      output mem_rd
   );

   modport slave (
      input  r0_req, r0_we, r0_byte_op, r0_lock, r0_addr, r0_wd,
      output r0_gnt, r0_rvalid, r0_rdata,
      input  r1_req, r1_we, r1_byte_op, r1_lock, r1_addr, r1_wd,
      output r1_gnt, r1_rvalid, r1_rdata,
      output mem_we, mem_byte_op, mem_addr, mem_wd,
      input  mem_rd
   );

endinterface

// File: rtl/data_mem_rr_pick.sv
// Two-way round-robin picker: one-hot grant, the side not granted last wins a tie.
// Purely combinational; no state.
module data_mem_rr_pick
   import data_mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_idx_t   last_gnt,
   output logic [1:0] gnt
);

   assign gnt[0] = req[0] & (~req[1] | last_gnt);
   assign gnt[1] = req[1] & (~req[0] | ~last_gnt);

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data memory between r0 (LSU) and r1 (DMA), with bounded locking.
// Grant is combinational in the request cycle; load data returns registered one cycle later.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   data_mem_arbiter_if.slave bus
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   arb_state_e            state_q, state_d;
   req_idx_t              last_gnt_q;
   logic [CW-1:0]         starve_cnt_q, starve_cnt_d;
   logic [1:0]            req, lock, rr_gnt, gnt, rvalid_q;
   req_idx_t              owner;
   logic                  own_act, starve_hit;
   mem_req_t              rq0, rq1, mem_req;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

   assign req  = {bus.r1_req,  bus.r0_req};
   assign lock = {bus.r1_lock, bus.r0_lock};
   assign rq0  = '{we: bus.r0_we, byte_op: bus.r0_byte_op, addr: bus.r0_addr, wd: bus.r0_wd};
   assign rq1  = '{we: bus.r1_we, byte_op: bus.r1_byte_op, addr: bus.r1_addr, wd: bus.r1_wd};

   // Ownership only matters while the owner still requests; otherwise fall back to round-robin.
   assign owner      = (state_q == OWN1);
   assign own_act    = (state_q != IDLE) && req[owner];
   assign starve_hit = own_act && req[other(owner)] && (starve_cnt_q == CW'(STARVE_LIMIT));

   data_mem_rr_pick u_pick (
      .req      (req),
      .last_gnt (last_gnt_q),
      .gnt      (rr_gnt)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         last_gnt_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         if (|gnt) last_gnt_q <= gnt[1];
      end
   end

   // The counter tracks consecutive locked beats taken while the other side is waiting.
   always_comb begin
      state_d      = IDLE;
      starve_cnt_d = '0;
      if ((|gnt) && lock[gnt[1]] && !starve_hit) begin
         state_d = gnt[1] ? OWN1 : OWN0;
         if (req[other(gnt[1])]) starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_comb begin
      gnt = '0;
      if (!rst_ni) begin
         gnt = '0;
      end else if (own_act) begin
         if (starve_hit) gnt[other(owner)] = 1'b1;
         else            gnt[owner]        = 1'b1;
      end else begin
         gnt = rr_gnt;
      end
      mem_req = '0;
      if (gnt[0])      mem_req = rq0;
      else if (gnt[1]) mem_req = rq1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         rvalid_q <= gnt & ~{bus.r1_we, bus.r0_we};
         if (gnt[0] && !bus.r0_we) rdata0_q <= bus.mem_rd;
         if (gnt[1] && !bus.r1_we) rdata1_q <= bus.mem_rd;
      end
   end

   assign bus.r0_gnt      = gnt[0];
   assign bus.r1_gnt      = gnt[1];
   assign bus.r0_rvalid   = rvalid_q[0];
   assign bus.r1_rvalid   = rvalid_q[1];
   assign bus.r0_rdata    = rdata0_q;
   assign bus.r1_rdata    = rdata1_q;
   assign bus.mem_we      = mem_req.we;
   assign bus.mem_byte_op = mem_req.byte_op;
   assign bus.mem_addr    = mem_req.addr;
   assign bus.mem_wd      = mem_req.wd;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random traffic checked
// every cycle against a queue-free behavioural model of ownership and memory.
module tb_data_mem_arbiter;

   localparam int LIMIT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_arbiter_if #(.DATA_WIDTH(32)) bus ();

   data_mem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] env_mem [64];
   logic [31:0] ref_mem [64];

   // model state: current lock owner (-1 = none), its locked streak, last granted side
   int          m_owner;
   int          m_streak;
   int          m_last;
   logic [1:0]  e_rvalid;
   logic [31:0] e_rdata [2];

   function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] b, input logic bo);
      return bo ? {24'h0, w[8*b +: 8]} : w;
   endfunction

   function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] b,
                                             input logic bo, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      if (bo) r[8*b +: 8] = d[7:0];
      else    r = d;
      return r;
   endfunction

   assign bus.mem_rd = load_val(env_mem[bus.mem_addr[7:2]], bus.mem_addr[1:0], bus.mem_byte_op);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner    = -1;
      m_streak   = 0;
      m_last     = 1;
      e_rvalid   = 2'b00;
      e_rdata[0] = '0;
      e_rdata[1] = '0;
   endtask

   task automatic check_cycle();
      logic [1:0]  q, lk, we, bo, eg;
      logic [31:0] ad [2];
      logic [31:0] wd [2];
      logic [31:0] e_addr, e_wd;
      logic        e_we, e_bo;
      int          g;
      bit          ovr;
      q  = {bus.r1_req, bus.r0_req};
      lk = {bus.r1_lock, bus.r0_lock};
      we = {bus.r1_we, bus.r0_we};
      bo = {bus.r1_byte_op, bus.r0_byte_op};
      ad[0] = bus.r0_addr; ad[1] = bus.r1_addr;
      wd[0] = bus.r0_wd;   wd[1] = bus.r1_wd;

      g   = -1;
      ovr = 0;
      if (!rst_n) g = -1;
      else if (m_owner >= 0 && q[m_owner]) begin
         if (q[1-m_owner] && m_streak == LIMIT) begin g = 1 - m_owner; ovr = 1; end
         else g = m_owner;
      end
      else if (q == 2'b11) g = 1 - m_last;
      else if (q[0])       g = 0;
      else if (q[1])       g = 1;

      eg = 2'b00;
      e_we = 1'b0; e_bo = 1'b0; e_addr = '0; e_wd = '0;
      if (g >= 0) begin
         eg[g]  = 1'b1;
         e_we   = we[g];
         e_bo   = bo[g];
         e_addr = ad[g];
         e_wd   = wd[g];
      end

      chk("gnt",         {30'd0, bus.r1_gnt, bus.r0_gnt}, {30'd0, eg});
      chk("mem_we",      bus.mem_we,      e_we);
      chk("mem_byte_op", bus.mem_byte_op, e_bo);
      chk("mem_addr",    bus.mem_addr,    e_addr);
      chk("mem_wd",      bus.mem_wd,      e_wd);
      chk("r0_rvalid",   bus.r0_rvalid,   e_rvalid[0]);
      chk("r1_rvalid",   bus.r1_rvalid,   e_rvalid[1]);
      chk("r0_rdata",    bus.r0_rdata,    e_rdata[0]);
      chk("r1_rdata",    bus.r1_rdata,    e_rdata[1]);

      // memory model seen by the DUT writes at negedge from whatever the DUT drives
      if (bus.mem_we)
         env_mem[bus.mem_addr[7:2]] = store_val(env_mem[bus.mem_addr[7:2]], bus.mem_addr[1:0],
                                                bus.mem_byte_op, bus.mem_wd);

      e_rvalid = 2'b00;
      if (g >= 0) begin
         if (we[g]) ref_mem[ad[g][7:2]] = store_val(ref_mem[ad[g][7:2]], ad[g][1:0], bo[g], wd[g]);
         else begin
            e_rvalid[g] = 1'b1;
            e_rdata[g]  = load_val(ref_mem[ad[g][7:2]], ad[g][1:0], bo[g]);
         end
         m_last = g;
         if (lk[g] && !ovr) begin
            m_streak = q[1-g] ? ((m_owner == g) ? m_streak + 1 : 1) : 0;
            m_owner  = g;
         end else begin
            m_owner  = -1;
            m_streak = 0;
         end
      end else begin
         m_owner  = -1;
         m_streak = 0;
      end
   endtask

   task automatic set_req(input int n, input logic we, input logic bo, input logic lk,
                          input logic [31:0] ad, input logic [31:0] wd);
      if (n == 0) begin
         bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_byte_op = bo;
         bus.r0_lock = lk;  bus.r0_addr = ad; bus.r0_wd = wd;
      end else begin
         bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_byte_op = bo;
         bus.r1_lock = lk;  bus.r1_addr = ad; bus.r1_wd = wd;
      end
   endtask

   task automatic clr(input int n);
      if (n == 0) begin bus.r0_req = 1'b0; bus.r0_lock = 1'b0; end
      else        begin bus.r1_req = 1'b0; bus.r1_lock = 1'b0; end
   endtask

   task automatic at_neg();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      clr(0); clr(1);
      rst_n = 1'b0;
      model_reset();
      at_neg();
      to_pos();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] seen;
      bit         pend;
      for (int i = 0; i < 64; i++) begin
         env_mem[i] = $urandom;
         ref_mem[i] = env_mem[i];
      end
      env_mem[4] = 32'hDEAD_BEEF;
      ref_mem[4] = 32'hDEAD_BEEF;
      set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
      to_pos();
      apply_reset();

      // 1: single word load
      set_req(0, 1'b0, 1'b0, 1'b0, 32'h10, '0);
      at_neg();
      chk("t1_r0_gnt", bus.r0_gnt, 1);
      chk("t1_r1_gnt", bus.r1_gnt, 0);
      to_pos(); clr(0);
      at_neg();
      chk("t1_r0_rvalid", bus.r0_rvalid, 1);
      chk("t1_r0_rdata", bus.r0_rdata, 32'hDEAD_BEEF);
      chk("t1_r1_rvalid", bus.r1_rvalid, 0);
      chk("t1_r1_rdata", bus.r1_rdata, 0);
      to_pos();

      // 2: simultaneous store / byte load after reset
      apply_reset();
      set_req(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1122_3344);
      set_req(1, 1'b0, 1'b1, 1'b0, 32'h20, '0);
      at_neg();
      chk("t2_r0_first", bus.r0_gnt, 1);
      chk("t2_r1_waits", bus.r1_gnt, 0);
      to_pos(); clr(0);
      at_neg();
      chk("t2_r1_second", bus.r1_gnt, 1);
      to_pos(); clr(1);
      at_neg();
      chk("t2_r1_rvalid", bus.r1_rvalid, 1);
      chk("t2_r1_rdata", bus.r1_rdata, 32'h0000_0044);
      to_pos();

      // 3: r0 locked burst with r1 idle, then a tie must go round-robin again
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1'b0, 1'b0, (i < 3), 32'h40 + 32'(4*i), '0);
         at_neg();
         chk("t3_r0_beat", bus.r0_gnt, 1);
         to_pos();
      end
      set_req(1, 1'b0, 1'b0, 1'b0, 32'h50, '0);
      at_neg();
      chk("t3_tie_r1", bus.r1_gnt, 1);
      to_pos(); clr(1);
      at_neg();
      to_pos(); clr(0);

      // 4: starvation limit
      apply_reset();
      set_req(0, 1'b0, 1'b0, 1'b1, 32'h10, '0);
      set_req(1, 1'b0, 1'b0, 1'b0, 32'h24, '0);
      for (int i = 0; i < 4; i++) begin
         at_neg();
         chk("t4_r0_locked", bus.r0_gnt, 1);
         chk("t4_r1_starved", bus.r1_gnt, 0);
         to_pos();
      end
      at_neg();
      chk("t4_r1_fifth", bus.r1_gnt, 1);
      chk("t4_r0_overridden", bus.r0_gnt, 0);
      to_pos(); clr(1);
      at_neg();
      to_pos(); clr(0);

      // 5: reset between r1 load grant and its response
      set_req(1, 1'b0, 1'b0, 1'b0, 32'h10, '0);
      at_neg();
      chk("t5_r1_gnt", bus.r1_gnt, 1);
      #2 rst_n = 1'b0;
      model_reset();
      #1 chk("t5_gnt_in_reset", bus.r1_gnt, 0);
      clr(1);
      #1 rst_n = 1'b1;
      to_pos();
      at_neg();
      chk("t5_r1_rvalid", bus.r1_rvalid, 0);
      to_pos();
      set_req(0, 1'b0, 1'b0, 1'b0, 32'h14, '0);
      set_req(1, 1'b0, 1'b0, 1'b0, 32'h18, '0);
      at_neg();
      chk("t5_tie_r0", bus.r0_gnt, 1);
      to_pos(); clr(0);
      at_neg();
      to_pos(); clr(1);

      // 6: owner drops request, other side granted in the same cycle
      set_req(0, 1'b1, 1'b0, 1'b1, 32'h30, 32'hA5A5_0001);
      at_neg();
      chk("t6_r0_lock", bus.r0_gnt, 1);
      to_pos(); clr(0);
      set_req(1, 1'b1, 1'b0, 1'b0, 32'h34, 32'h5A5A_0002);
      at_neg();
      chk("t6_r1_same_cycle", bus.r1_gnt, 1);
      to_pos(); clr(1);
      at_neg();
      chk("t6_idle_we", bus.mem_we, 0);
      chk("t6_idle_addr", bus.mem_addr, 0);
      to_pos();

      // random traffic: each requester holds until granted, then maybe issues again
      seen = 2'b00;
      for (int c = 0; c < 3000; c++) begin
         for (int n = 0; n < 2; n++) begin
            pend = (n == 0) ? bus.r0_req : bus.r1_req;
            if (!pend || seen[n]) begin
               if ($urandom_range(0, 3) != 0)
                  set_req(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0), 32'($urandom_range(0, 255)), $urandom);
               else
                  clr(n);
            end
         end
         at_neg();
         seen = {bus.r1_gnt, bus.r0_gnt};
         to_pos();
      end
      clr(0); clr(1);
      at_neg();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
